imem_boot_sequencer: RTL and testbench

//  Boot/run sequencer for the pipelined RISC-V core. Streams a program image into instruction memory via its external port, then reads it back and checks a checksum.
//  On a match, releases the core from reset and runs it for a bounded number of cycles or until halt.

---
 rtl/imem_boot_sequencer.sv | 179 +++++++++++++++++
 tb/tb_imem_boot_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_sequencer.sv
// Boot/run sequencer: streams a program image into instruction memory, reads it back
// against the load checksum, then releases the core for a bounded run or until halt.
module imem_boot_sequencer #(
    parameter int IMEM_WORDS = 512,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             start,
    input  logic             abort,
    input  logic [9:0]       prog_len,
    input  logic [CNT_W-1:0] run_cycles,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [31:0]      s_data,
    output logic [63:0]      imem_addr,
    output logic             imem_wen,
    output logic             imem_ren,
    output logic [31:0]      imem_wdata,
    input  logic [31:0]      imem_rdata,
    input  logic             halt,
    output logic             cpu_arst_n,
    output logic             cpu_enable,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [1:0]       err_code,
    output logic [31:0]      checksum,
    output logic [CNT_W-1:0] cycles_used
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_VERIFY = 3'd2;
    localparam logic [2:0] S_RUN    = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
    localparam logic [2:0] S_ERROR  = 3'd5;

    localparam logic [10:0]      MAX_LEN = 11'(IMEM_WORDS);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [2:0]       state, state_nxt;
    logic [9:0]       plen;
    logic [9:0]       idx;
    logic [9:0]       rd_idx;
    logic [9:0]       ret_cnt;
    logic [CNT_W-1:0] run_budget;
    logic [CNT_W-1:0] cu_inc;
    logic [31:0]      rd_sum, rd_sum_nxt;
    logic             rd_pend;
    logic             len_ok;
    logic             last_ret;
    logic             budget_hit;

    assign len_ok     = (prog_len != 10'd0) && ({1'b0, prog_len} <= MAX_LEN);
    assign rd_sum_nxt = rd_sum + imem_rdata;
    assign last_ret   = rd_pend && (ret_cnt == plen - 10'd1);
    assign cu_inc     = cycles_used + CNT_ONE;
    // First RUN cycle has cpu_enable low; only a zero budget can end it there.
    assign budget_hit = cpu_enable ? (cu_inc == run_budget) : (run_budget == '0);

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERROR: if (start) state_nxt = len_ok ? S_LOAD : S_ERROR;
                S_LOAD:   if (idx == plen) state_nxt = S_VERIFY;
                S_VERIFY: if (last_ret) state_nxt = (rd_sum_nxt == checksum) ? S_RUN : S_ERROR;
                S_RUN:    if (budget_hit || halt) state_nxt = S_DONE;
                default:  state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state       <= S_IDLE;
            plen        <= '0;
            idx         <= '0;
            rd_idx      <= '0;
            ret_cnt     <= '0;
            run_budget  <= '0;
            rd_sum      <= '0;
            rd_pend     <= 1'b0;
            s_ready     <= 1'b0;
            imem_addr   <= '0;
            imem_wen    <= 1'b0;
            imem_ren    <= 1'b0;
            imem_wdata  <= '0;
            cpu_arst_n  <= 1'b0;
            cpu_enable  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            err_code    <= 2'b00;
            checksum    <= '0;
            cycles_used <= '0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == S_LOAD) || (state_nxt == S_VERIFY) || (state_nxt == S_RUN);
            done  <= (state_nxt == S_DONE);
            error <= (state_nxt == S_ERROR);

            // Memory port is idle unless a write or read is issued below.
            imem_wen   <= 1'b0;
            imem_ren   <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            rd_pend    <= imem_ren;

            if (abort) begin
                s_ready    <= 1'b0;
                cpu_arst_n <= 1'b0;
                cpu_enable <= 1'b0;
                err_code   <= 2'b00;
            end else begin
                case (state)
                    S_IDLE, S_DONE, S_ERROR: begin
                        if (start) begin
                            cpu_arst_n <= 1'b0;
                            cpu_enable <= 1'b0;
                            if (!len_ok) begin
                                err_code <= 2'b01;
                            end else begin
                                plen        <= prog_len;
                                run_budget  <= run_cycles;
                                idx         <= '0;
                                checksum    <= '0;
                                cycles_used <= '0;
                                err_code    <= 2'b00;
                                s_ready     <= 1'b1;
                            end
                        end
                    end
                    S_LOAD: begin
                        if (s_valid && s_ready) begin
                            imem_wen   <= 1'b1;
                            imem_addr  <= 64'({idx, 2'b00});
                            imem_wdata <= s_data;
                            checksum   <= checksum + s_data;
                            idx        <= idx + 10'd1;
                            s_ready    <= (idx + 10'd1) < plen;
                        end
                        // Leaving LOAD issues the read of word 0 (address already 0).
                        if (state_nxt == S_VERIFY) begin
                            imem_ren <= 1'b1;
                            rd_idx   <= 10'd1;
                            rd_sum   <= '0;
                            ret_cnt  <= '0;
                        end
                    end
                    S_VERIFY: begin
                        if (rd_idx < plen) begin
                            imem_ren  <= 1'b1;
                            imem_addr <= 64'({rd_idx, 2'b00});
                            rd_idx    <= rd_idx + 10'd1;
                        end
                        if (rd_pend) begin
                            rd_sum  <= rd_sum_nxt;
                            ret_cnt <= ret_cnt + 10'd1;
                        end
                        if (state_nxt == S_RUN)   cpu_arst_n <= 1'b1;
                        if (state_nxt == S_ERROR) err_code   <= 2'b10;
                    end
                    S_RUN: begin
                        if (cpu_enable) cycles_used <= cu_inc;
                        cpu_enable <= (state_nxt == S_RUN);
                    end
                    default: begin
                        cpu_enable <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_boot_sequencer.sv
// Scoreboarded bench for imem_boot_sequencer: expected writes queued at each handshake,
// popped as the DUT issues them; run results checked against a bench-side model.
module tb_imem_boot_sequencer;
    localparam int IMEM_WORDS = 512;
    localparam int CNT_W      = 32;

    logic             clk = 1'b0, arst = 1'b1, start = 1'b0, abort = 1'b0;
    logic             s_valid = 1'b0, halt = 1'b0;
    logic [9:0]       prog_len = '0;
    logic [CNT_W-1:0] run_cycles = '0;
    logic [31:0]      s_data = '0;
    logic             s_ready, imem_wen, imem_ren, cpu_arst_n, cpu_enable, busy, done, error;
    logic [63:0]      imem_addr;
    logic [31:0]      imem_wdata, checksum;
    logic [31:0]      imem_rdata = '0;
    logic [1:0]       err_code;
    logic [CNT_W-1:0] cycles_used;

    int n_chk = 0, n_err = 0;
    logic [31:0] mem [0:IMEM_WORDS-1];
    logic [31:0] img [0:IMEM_WORDS-1];
    bit          corrupt = 1'b0;
    logic [95:0] sb [$];
    int wen_tot = 0, wen_rise = 0, en_tot = 0, arstn_tot = 0;
    logic wen_q = 1'b0;

    always #5 clk = ~clk;

    imem_boot_sequencer #(.IMEM_WORDS(IMEM_WORDS), .CNT_W(CNT_W)) dut (
        .clk(clk), .arst(arst), .start(start), .abort(abort),
        .prog_len(prog_len), .run_cycles(run_cycles),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .imem_addr(imem_addr), .imem_wen(imem_wen), .imem_ren(imem_ren),
        .imem_wdata(imem_wdata), .imem_rdata(imem_rdata),
        .halt(halt), .cpu_arst_n(cpu_arst_n), .cpu_enable(cpu_enable),
        .busy(busy), .done(done), .error(error), .err_code(err_code),
        .checksum(checksum), .cycles_used(cycles_used)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Memory model: read data valid the cycle after imem_ren; optional corruption of word 2.
    always @(posedge clk) begin
        if (imem_wen) mem[imem_addr[10:2]] <= imem_wdata;
        if (imem_ren)
            imem_rdata <= mem[imem_addr[10:2]] ^
                          ((corrupt && imem_addr[10:2] == 9'd2) ? 32'h0000_0100 : 32'h0);
    end

    always @(negedge clk) begin : mon
        logic [95:0] e;
        if (imem_wen) begin
            wen_tot++;
            if (!wen_q) wen_rise++;
            if (sb.size() == 0) chk("sb_underflow", 64'd1, 64'd0);
            else begin
                e = sb.pop_front();
                chk("wr_addr", imem_addr, e[95:32]);
                chk("wr_data", {32'h0, imem_wdata}, {32'h0, e[31:0]});
            end
        end
        wen_q = imem_wen;
        if (cpu_enable) en_tot++;
        if (cpu_arst_n) arstn_tot++;
    end

    task automatic do_start(input logic [9:0] len, input logic [CNT_W-1:0] rcy);
        @(negedge clk); prog_len = len; run_cycles = rcy; start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic stream(input int n, input bit tog);
        int i = 0;
        int c = 0;
        bit ph = 1'b1;
        while (i < n && c < 4 * n + 20) begin
            @(negedge clk);
            s_valid = tog ? ph : 1'b1;
            ph = ~ph;
            s_data = img[i];
            if (s_valid && s_ready) begin
                sb.push_back({64'(i * 4), img[i]});
                i++;
            end
            c++;
        end
        @(negedge clk); s_valid = 1'b0;
        chk("stream_words", 64'(i), 64'(n));
    endtask

    task automatic wait_end(input int lim);
        int c = 0;
        while (!(done || error) && c < lim) begin @(negedge clk); c++; end
        chk("end_reached", {63'd0, done || error}, 64'd1);
    endtask

    function automatic logic [31:0] sum_img(input int n);
        logic [31:0] s = '0;
        for (int i = 0; i < n; i++) s = s + img[i];
        return s;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int w0, r0, e0, a0, c;
        repeat (3) @(negedge clk);
        chk("rst_busy", {63'd0, busy}, 0);
        chk("rst_done", {63'd0, done}, 0);
        chk("rst_error", {63'd0, error}, 0);
        chk("rst_arst_n", {63'd0, cpu_arst_n}, 0);
        chk("rst_sready", {63'd0, s_ready}, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_sum", {32'h0, checksum}, 0);
        chk("rst_cyc", {32'h0, cycles_used}, 0);
        arst = 1'b0;

        // Basic program, steady stream
        img[0] = 32'h00000013; img[1] = 32'h00100093;
        img[2] = 32'h00200113; img[3] = 32'h002081B3;
        w0 = wen_tot; r0 = wen_rise;
        do_start(10'd4, 20);
        stream(4, 1'b0);
        wait_end(200);
        chk("t1_done", {63'd0, done}, 1);
        chk("t1_sum", {32'h0, checksum}, {32'h0, sum_img(4)});
        chk("t1_cyc", {32'h0, cycles_used}, 20);
        chk("t1_writes", 64'(wen_tot - w0), 4);
        chk("t1_consec", 64'(wen_rise - r0), 1);
        chk("t1_sb_empty", 64'(sb.size()), 0);
        chk("t1_arst_n_done", {63'd0, cpu_arst_n}, 1);
        chk("t1_en_done", {63'd0, cpu_enable}, 0);

        // Halt raised in RUN cycle 10
        img[0] = 32'hDEAD0001; img[1] = 32'h12345678;
        do_start(10'd2, 100);
        stream(2, 1'b0);
        c = 0;
        while (!cpu_arst_n && c < 100) begin @(negedge clk); c++; end
        chk("h_run_seen", {63'd0, cpu_arst_n}, 1);
        repeat (9) @(negedge clk);
        chk("h_en_c10", {63'd0, cpu_enable}, 1);
        halt = 1'b1;
        @(negedge clk); halt = 1'b0;
        chk("h_done", {63'd0, done}, 1);
        chk("h_en_off", {63'd0, cpu_enable}, 0);
        chk("h_cyc", {32'h0, cycles_used}, 9);

        // s_valid toggling 1,0,1,0,1 with prog_len=3
        img[0] = 32'hA5A5A5A5; img[1] = 32'h0F0F0F0F; img[2] = 32'hFFFFFFFF;
        w0 = wen_tot; r0 = wen_rise;
        do_start(10'd3, 5);
        stream(3, 1'b1);
        wait_end(200);
        chk("tg_done", {63'd0, done}, 1);
        chk("tg_writes", 64'(wen_tot - w0), 3);
        chk("tg_gaps", 64'(wen_rise - r0), 3);
        chk("tg_sb_empty", 64'(sb.size()), 0);
        chk("tg_sum", {32'h0, checksum}, {32'h0, sum_img(3)});
        chk("tg_cyc", {32'h0, cycles_used}, 5);

        // Zero run budget
        e0 = en_tot;
        do_start(10'd2, 0);
        stream(2, 1'b0);
        wait_end(200);
        chk("z_done", {63'd0, done}, 1);
        chk("z_no_en", 64'(en_tot - e0), 0);
        chk("z_cyc", {32'h0, cycles_used}, 0);

        // Illegal lengths
        do_start(10'd0, 5);
        w0 = wen_tot; a0 = arstn_tot;
        repeat (3) @(negedge clk);
        chk("l0_error", {63'd0, error}, 1);
        chk("l0_code", {62'd0, err_code}, 1);
        chk("l0_no_wen", 64'(wen_tot - w0), 0);
        chk("l0_arst_n", 64'(arstn_tot - a0), 0);
        do_start(10'd513, 5);
        w0 = wen_tot; a0 = arstn_tot;
        repeat (3) @(negedge clk);
        chk("l513_error", {63'd0, error}, 1);
        chk("l513_code", {62'd0, err_code}, 1);
        chk("l513_no_wen", 64'(wen_tot - w0), 0);
        chk("l513_arst_n", 64'(arstn_tot - a0), 0);

        // Readback corruption
        img[0] = 32'h00000013; img[1] = 32'h00100093;
        img[2] = 32'h00200113; img[3] = 32'h002081B3;
        corrupt = 1'b1;
        e0 = en_tot;
        do_start(10'd4, 20);
        stream(4, 1'b0);
        wait_end(200);
        chk("cs_error", {63'd0, error}, 1);
        chk("cs_code", {62'd0, err_code}, 2);
        chk("cs_no_en", 64'(en_tot - e0), 0);
        corrupt = 1'b0;

        // Abort during VERIFY, then a normal run
        for (int i = 0; i < 8; i++) img[i] = $urandom;
        do_start(10'd8, 50);
        stream(8, 1'b0);
        c = 0;
        while (!imem_ren && c < 50) begin @(negedge clk); c++; end
        chk("ab_in_verify", {63'd0, imem_ren}, 1);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        chk("ab_busy", {63'd0, busy}, 0);
        chk("ab_ren", {63'd0, imem_ren}, 0);
        chk("ab_en", {63'd0, cpu_enable}, 0);
        chk("ab_arst_n", {63'd0, cpu_arst_n}, 0);
        chk("ab_sum_hold", {32'h0, checksum}, {32'h0, sum_img(8)});
        do_start(10'd4, 20);
        stream(4, 1'b0);
        wait_end(200);
        chk("ab_re_done", {63'd0, done}, 1);
        chk("ab_re_cyc", {32'h0, cycles_used}, 20);

        // Async reset pulse during RUN, then a normal run
        do_start(10'd4, 30);
        stream(4, 1'b0);
        c = 0;
        while (!cpu_enable && c < 100) begin @(negedge clk); c++; end
        chk("ar_running", {63'd0, cpu_enable}, 1);
        arst = 1'b1;
        #1;
        chk("ar_busy", {63'd0, busy}, 0);
        chk("ar_en", {63'd0, cpu_enable}, 0);
        chk("ar_arst_n", {63'd0, cpu_arst_n}, 0);
        chk("ar_sum", {32'h0, checksum}, 0);
        chk("ar_cyc", {32'h0, cycles_used}, 0);
        @(negedge clk); arst = 1'b0;
        do_start(10'd3, 7);
        stream(3, 1'b0);
        wait_end(200);
        chk("ar_re_done", {63'd0, done}, 1);
        chk("ar_re_cyc", {32'h0, cycles_used}, 7);
        chk("ar_re_sum", {32'h0, checksum}, {32'h0, sum_img(3)});
        chk("final_sb_empty", 64'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
